// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Brief   : MEM-stage data-memory controller with byte-lane RAM, configurable
//           read latency, load extension and a pipeline stall.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH_LOG2 = 14,
  parameter int RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addrs,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] c_LAST = 3'(RD_LAT - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [31:0] r_rd_word;
  logic [31:0] r_rdata;
  logic [2:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_sgn;
  logic        r_done;
  logic        r_misal;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]  w_lane;
  logic        w_aligned;
  logic        w_accept;
  logic        w_ld_go;
  logic        w_st_go;
  logic        w_misal_go;
  logic [2:0]  w_cnt_nxt;
  logic        w_busy_last;
  logic        w_ld_fin;
  logic [3:0]  w_be;
  logic [31:0] w_wword;
  logic [31:0] w_src_word;
  logic [1:0]  w_src_lane;
  logic [1:0]  w_src_size;
  logic        w_src_sgn;
  logic        w_unused_addr;

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic sg);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    v_b = word[{lane, 3'b000} +: 8];
    v_h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   return {{24{sg & v_b[7]}}, v_b};
      2'b01:   return {{16{sg & v_h[15]}}, v_h};
      default: return word;
    endcase
  endfunction

  assign w_idx         = addrs[DEPTH_LOG2+1:2];
  assign w_lane        = addrs[1:0];
  assign w_unused_addr = ^addrs[31:DEPTH_LOG2+2];

  always_comb begin
    w_aligned = 1'b1;
    case (size)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~addrs[0];
      default: w_aligned = (addrs[1:0] == 2'b00);
    endcase
  end

  // Gating with rst keeps the RAM and stall quiet while reset is held.
  assign w_accept    = rst & (r_state == S_IDLE) & req;
  assign w_ld_go     = w_accept & ~we & w_aligned;
  assign w_st_go     = w_accept & we & w_aligned;
  assign w_misal_go  = w_accept & ~w_aligned;
  assign w_cnt_nxt   = r_cnt + 3'd1;
  assign w_busy_last = (r_state == S_BUSY) && (w_cnt_nxt == c_LAST);
  assign w_ld_fin    = (RD_LAT == 1) ? w_ld_go : w_busy_last;

  // Single-cycle latency extracts straight from the array at acceptance.
  assign w_src_word = (RD_LAT == 1) ? r_mem[w_idx] : r_rd_word;
  assign w_src_lane = (RD_LAT == 1) ? w_lane : r_lane;
  assign w_src_size = (RD_LAT == 1) ? size : r_size;
  assign w_src_sgn  = (RD_LAT == 1) ? sgn : r_sgn;

  always_comb begin
    w_be    = 4'b1111;
    w_wword = wdata;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wword = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wword = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_st_go) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
    if (w_ld_go) r_rd_word <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ld_go) w_state_nxt = (RD_LAT == 1) ? S_RESP : S_BUSY;
      S_BUSY:  if (w_busy_last) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 3'd0;
      r_lane  <= 2'd0;
      r_size  <= 2'd0;
      r_sgn   <= 1'b0;
      r_done  <= 1'b0;
      r_misal <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_done  <= w_st_go | w_misal_go | w_ld_fin;
      r_misal <= w_misal_go;
      if (w_ld_go) begin
        r_cnt  <= 3'd0;
        r_lane <= w_lane;
        r_size <= size;
        r_sgn  <= sgn;
      end else if (r_state == S_BUSY) begin
        r_cnt <= w_cnt_nxt;
      end
      if (w_misal_go)    r_rdata <= 32'd0;
      else if (w_ld_fin) r_rdata <= f_extend(w_src_word, w_src_lane, w_src_size, w_src_sgn);
    end
  end

  assign stall    = rst & (w_ld_go | (r_state == S_BUSY));
  assign done     = r_done;
  assign misalign = r_misal;
  assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_ctrl
// Brief   : Self-checking bench for data_mem_ctrl against a byte-array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;
  localparam int DL = 14;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        sgn = 1'b0;
  logic [31:0] addrs = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misalign;

  logic [7:0] m_mem [0:65535];
  int n_checks = 0;
  int n_err = 0;

  data_mem_ctrl #(.DEPTH_LOG2(DL), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sgn(sgn),
    .addrs(addrs), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic bit is_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  // Byte-addressed, little-endian view of the RAM; wraps at 64 KB.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg, input logic [31:0] a);
    int b;
    longint v;
    b = a % 65536;
    if (sz == 2'd0) begin
      v = m_mem[b];
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = m_mem[b] + 256 * m_mem[b+1];
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = m_mem[b] + 256 * m_mem[b+1] + 65536 * m_mem[b+2] + 16777216 * longint'(m_mem[b+3]);
    end
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b;
    int n;
    b = a % 65536;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) m_mem[b+k] = 8'((d >> (8*k)) & 32'hFF);
  endtask

  // Starts at posedge+1; returns at posedge+1 with the controller idle.
  task automatic access(input bit iwe, input logic [1:0] isz, input bit isgn,
                        input logic [31:0] ia, input logic [31:0] iwd, input string tag);
    bit al;
    bit ld;
    bit got;
    int cyc;
    int exp_cyc;
    logic [31:0] exp_rd;
    al = is_aligned(isz, ia);
    ld = !iwe && al;
    exp_cyc = ld ? RL : 1;
    exp_rd = ld ? model_load(isz, isgn, ia) : 32'd0;
    req = 1'b1; we = iwe; size = isz; sgn = isgn; addrs = ia; wdata = iwd;
    #1;
    n_checks++;
    if (stall !== ld) begin
      n_err++;
      $display("FAIL %s stall_cycle0: got %b expected %b", tag, stall, ld);
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) begin
        got = 1'b1;
      end else if (ld) begin
        n_checks++;
        if (stall !== 1'b1) begin
          n_err++;
          $display("FAIL %s stall_busy: got %b expected 1 at cycle %0d", tag, stall, cyc);
        end
      end
      if (!ld) req = 1'b0;
    end
    n_checks++;
    if (!got) begin
      n_err++;
      $display("FAIL %s done_timeout: got no done expected done at cycle %0d", tag, exp_cyc);
    end else begin
      n_checks++;
      if (cyc != exp_cyc) begin
        n_err++;
        $display("FAIL %s done_latency: got %0d expected %0d", tag, cyc, exp_cyc);
      end
      n_checks++;
      if (misalign !== !al || stall !== 1'b0) begin
        n_err++;
        $display("FAIL %s misalign_stall: got misalign=%b stall=%b expected misalign=%b stall=0",
                 tag, misalign, stall, !al);
      end
      if (!(iwe && al)) begin
        n_checks++;
        if (rdata !== exp_rd) begin
          n_err++;
          $display("FAIL %s rdata: got %h expected %h", tag, rdata, exp_rd);
        end
      end
    end
    req = 1'b0;
    if (iwe && al) model_store(isz, ia, iwd);
    if (ld) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || stall !== 1'b0) begin
        n_err++;
        $display("FAIL %s no_reaccept: got done=%b stall=%b expected 0 0", tag, done, stall);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b1; we = 1'b0; size = 2'd2; addrs = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (rdata !== 32'd0 || done !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got rdata=%h done=%b mis=%b stall=%b expected all 0",
                 rdata, done, misalign, stall);
      end
    end
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "store_word");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "load_word");
  endtask

  task automatic test_byte_ext();
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000080, "store_byte");
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "load_byte_s");
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "load_byte_u");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "load_word_merge");
    access(1'b1, 2'd1, 1'b0, 32'h16, 32'h0000F00D, "store_half");
    access(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, "load_half_s");
  endtask

  task automatic test_misalign();
    access(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, "mis_half_load");
    access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, "mis_word_load");
    access(1'b1, 2'd3, 1'b0, 32'h12, 32'h12345678, "mis_word_store");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "after_mis_load");
  endtask

  task automatic test_wrap();
    access(1'b1, 2'd2, 1'b0, 32'h00010010, 32'hA5A55A5A, "wrap_store");
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "wrap_load");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) access(1'b1, 2'd2, 1'b0, 32'(32 + 4*i), $urandom, "b2b_store");
    access(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000C3, "b2b_store_byte");
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "b2b_load_new");
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) access(1'b1, 2'd2, 1'b0, 32'(4*i), $urandom, "rand_init");
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 3)) << 16);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, "rand_op");
    end
  endtask

  task automatic test_reset_busy();
    req = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; addrs = 32'h10;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 32'd0 || done !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL busy_reset_outputs: got rdata=%h done=%b mis=%b stall=%b expected all 0",
               rdata, done, misalign, stall);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || stall !== 1'b0) begin
        n_err++;
        $display("FAIL busy_reset_no_done: got done=%b stall=%b expected 0 0", done, stall);
      end
    end
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "load_after_reset");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) m_mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_byte_ext();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
